// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the 8-bit EX ALU.
// Holds one decoded instruction behind a valid/ready handshake, forwards
// results from MEM (at the output) and WB (at capture and while stalled),
// and supports a synchronous flush for branch redirects.
module id_ex_stage #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [1:0]            id_alu_ctrl,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [DATA_W-1:0]     id_rs1_data,
    input  logic [DATA_W-1:0]     id_rs2_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic                  id_use_imm,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [DATA_W-1:0]     mem_result,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic [DATA_W-1:0]     wb_result,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [1:0]            alu_ctrl,
    output logic [DATA_W-1:0]     alu_in_1,
    output logic [DATA_W-1:0]     alu_in_2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write
);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0]     DATA_ZERO = {DATA_W{1'b0}};

    // A producer matches a source only if it writes, targets that register,
    // and the register is not the hard-wired zero register.
    function automatic logic fwd_match(
        input logic                  prod_we,
        input logic [REG_ADDR_W-1:0] prod_rd,
        input logic [REG_ADDR_W-1:0] rs
    );
        return prod_we && (prod_rd == rs) && (rs != REG_ZERO);
    endfunction

    // Operand seen at capture time: x0 is always zero, WB bypasses the regfile.
    function automatic logic [DATA_W-1:0] capture_operand(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [DATA_W-1:0]     rf_data,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_dst,
        input logic [DATA_W-1:0]     wb_data
    );
        if (rs == REG_ZERO) begin
            return DATA_ZERO;
        end else if (fwd_match(wb_we, wb_dst, rs)) begin
            return wb_data;
        end else begin
            return rf_data;
        end
    endfunction

    logic                  valid_q,     valid_d;
    logic [1:0]            ctrl_q,      ctrl_d;
    logic [REG_ADDR_W-1:0] rs1_q,       rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q,       rs2_d;
    logic [DATA_W-1:0]     op1_q,       op1_d;
    logic [DATA_W-1:0]     op2_q,       op2_d;
    logic [DATA_W-1:0]     imm_q,       imm_d;
    logic                  use_imm_q,   use_imm_d;
    logic [REG_ADDR_W-1:0] rd_q,        rd_d;
    logic                  reg_write_q, reg_write_d;

    logic id_ready_s;
    logic transfer_s;

    assign id_ready_s = !valid_q || ex_ready;
    assign transfer_s = id_valid && id_ready_s;
    assign id_ready   = id_ready_s;

    // Next-state: capture on transfer, otherwise hold with WB operand refresh.
    always_comb begin
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;

        if (transfer_s) begin
            // Data fields may load even under flush; valid below kills it.
            ctrl_d      = id_alu_ctrl;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            op1_d       = capture_operand(id_rs1, id_rs1_data, wb_reg_write, wb_rd, wb_result);
            op2_d       = capture_operand(id_rs2, id_rs2_data, wb_reg_write, wb_rd, wb_result);
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            rd_d        = id_rd;
            reg_write_d = id_reg_write;
        end else if (valid_q) begin
            // A producer retiring while we wait must not leave a stale operand.
            if (fwd_match(wb_reg_write, wb_rd, rs1_q)) begin
                op1_d = wb_result;
            end else begin
                op1_d = op1_q;
            end
            if (fwd_match(wb_reg_write, wb_rd, rs2_q)) begin
                op2_d = wb_result;
            end else begin
                op2_d = op2_q;
            end
        end else begin
            op1_d = op1_q;
            op2_d = op2_q;
        end

        if (flush) begin
            valid_d = 1'b0;
        end else if (id_ready_s) begin
            valid_d = id_valid;
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline register state, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            ctrl_q      <= 2'b00;
            rs1_q       <= REG_ZERO;
            rs2_q       <= REG_ZERO;
            op1_q       <= DATA_ZERO;
            op2_q       <= DATA_ZERO;
            imm_q       <= DATA_ZERO;
            use_imm_q   <= 1'b0;
            rd_q        <= REG_ZERO;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
        end
    end

    // Output operands: MEM bypass wins over the stored (WB-refreshed) value;
    // the immediate path is never forwarded.
    always_comb begin
        if (fwd_match(mem_reg_write, mem_rd, rs1_q)) begin
            alu_in_1 = mem_result;
        end else begin
            alu_in_1 = op1_q;
        end

        if (use_imm_q) begin
            alu_in_2 = imm_q;
        end else if (fwd_match(mem_reg_write, mem_rd, rs2_q)) begin
            alu_in_2 = mem_result;
        end else begin
            alu_in_2 = op2_q;
        end
    end

    assign ex_valid     = valid_q;
    assign alu_ctrl     = ctrl_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX-side outputs are queued
// when an instruction is offered and compared when it appears at the output.
module tb_id_ex_stage;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       id_valid;
    logic       id_ready;
    logic [1:0] id_alu_ctrl;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [7:0] id_rs1_data, id_rs2_data, id_imm;
    logic       id_use_imm, id_reg_write;
    logic [4:0] mem_rd, wb_rd;
    logic       mem_reg_write, wb_reg_write;
    logic [7:0] mem_result, wb_result;
    logic       ex_ready;
    logic       ex_valid;
    logic [1:0] alu_ctrl;
    logic [7:0] alu_in_1, alu_in_2;
    logic [4:0] ex_rd;
    logic       ex_reg_write;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0] ctrl;
        logic [7:0] in1;
        logic [7:0] in2;
        logic [4:0] rd;
        logic       rw;
    } exp_t;

    exp_t sb_q[$];

    id_ex_stage #(.DATA_W(8), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_alu_ctrl(id_alu_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .alu_ctrl(alu_ctrl), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] c, input logic [4:0] r1, input logic [7:0] d1,
                         input logic [4:0] r2, input logic [7:0] d2, input logic [7:0] imm,
                         input logic ui, input logic [4:0] rd, input logic rw);
        id_valid = 1'b1; id_alu_ctrl = c;
        id_rs1 = r1; id_rs1_data = d1; id_rs2 = r2; id_rs2_data = d2;
        id_imm = imm; id_use_imm = ui; id_rd = rd; id_reg_write = rw;
    endtask

    task automatic sb_push(input logic [1:0] c, input logic [7:0] i1, input logic [7:0] i2,
                           input logic [4:0] rd, input logic rw);
        exp_t e;
        e.ctrl = c; e.in1 = i1; e.in2 = i2; e.rd = rd; e.rw = rw;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_ctrl"}, {30'd0, alu_ctrl}, {30'd0, e.ctrl});
            chk({tag, "_in1"}, {24'd0, alu_in_1}, {24'd0, e.in1});
            chk({tag, "_in2"}, {24'd0, alu_in_2}, {24'd0, e.in2});
            chk({tag, "_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
            chk({tag, "_rw"}, {31'd0, ex_reg_write}, {31'd0, e.rw});
        end
    endtask

    initial begin
        // Reset with random inputs
        rst_n = 1'b0; flush = 1'b0;
        id_valid = 1'($urandom); id_alu_ctrl = 2'($urandom);
        id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
        id_rs1_data = 8'($urandom); id_rs2_data = 8'($urandom); id_imm = 8'($urandom);
        id_use_imm = 1'($urandom); id_reg_write = 1'($urandom);
        mem_rd = 5'($urandom); mem_reg_write = 1'($urandom); mem_result = 8'($urandom);
        wb_rd = 5'($urandom); wb_reg_write = 1'($urandom); wb_result = 8'($urandom);
        ex_ready = 1'($urandom);
        tick(); tick();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_in1", {24'd0, alu_in_1}, 32'd0);
        chk("rst_in2", {24'd0, alu_in_2}, 32'd0);
        chk("rst_ctrl", {30'd0, alu_ctrl}, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("rst_ready", {31'd0, id_ready}, 32'd1);

        // First transfer, 1-cycle latency
        rst_n = 1'b1; id_valid = 1'b0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0; ex_ready = 1'b1;
        tick();
        offer(2'd2, 5'd1, 8'd5, 5'd2, 8'd3, 8'd0, 1'b0, 5'd7, 1'b1);
        sb_push(2'd2, 8'd5, 8'd3, 5'd7, 1'b1);
        #1 chk("xfer_ready", {31'd0, id_ready}, 32'd1);
        tick();
        id_valid = 1'b0;
        sb_pop("xfer1");

        // Bubble when nothing offered
        tick();
        chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("bubble_rw", {31'd0, ex_reg_write}, 32'd0);

        // MEM forward on held rs1, MEM beats WB
        offer(2'd0, 5'd4, 8'h11, 5'd5, 8'h33, 8'h00, 1'b0, 5'd6, 1'b1);
        sb_push(2'd0, 8'h11, 8'h33, 5'd6, 1'b1);
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        sb_pop("memfwd_cap");
        mem_reg_write = 1'b1; mem_rd = 5'd4; mem_result = 8'hA5;
        wb_reg_write = 1'b1; wb_rd = 5'd4; wb_result = 8'h22;
        #1 chk("memfwd_in1", {24'd0, alu_in_1}, 32'h0000_00A5);
        mem_reg_write = 1'b0;
        #1 chk("memfwd_drop", {24'd0, alu_in_1}, 32'h0000_0011);
        wb_reg_write = 1'b0;

        // x0 guard at capture (WB) and output (MEM)
        ex_ready = 1'b1;
        offer(2'd1, 5'd1, 8'h01, 5'd0, 8'h7F, 8'h00, 1'b0, 5'd8, 1'b0);
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 8'h99;
        wb_rd = 5'd0; wb_reg_write = 1'b1; wb_result = 8'h55;
        sb_push(2'd1, 8'h01, 8'h00, 5'd8, 1'b0);
        tick();
        sb_pop("x0");

        // Immediate path ignores a MEM match on rs2
        offer(2'd3, 5'd1, 8'h02, 5'd6, 8'h44, 8'h0C, 1'b1, 5'd9, 1'b1);
        mem_rd = 5'd6; mem_reg_write = 1'b1; mem_result = 8'h99;
        wb_reg_write = 1'b0;
        sb_push(2'd3, 8'h02, 8'h0C, 5'd9, 1'b1);
        tick();
        sb_pop("imm");

        // Capture-time WB forward on rs1 and rs2
        offer(2'd2, 5'd9, 8'h10, 5'd9, 8'h20, 8'h00, 1'b0, 5'd10, 1'b1);
        mem_reg_write = 1'b0;
        wb_rd = 5'd9; wb_reg_write = 1'b1; wb_result = 8'h77;
        sb_push(2'd2, 8'h77, 8'h77, 5'd10, 1'b1);
        tick();
        wb_reg_write = 1'b0;
        sb_pop("wbcap");

        // Stall with WB refresh; a pending offer must not be taken
        offer(2'd1, 5'd3, 8'h10, 5'd2, 8'h05, 8'h00, 1'b0, 5'd11, 1'b1);
        sb_push(2'd1, 8'h10, 8'h05, 5'd11, 1'b1);
        tick();
        sb_pop("stall_cap");
        ex_ready = 1'b0;
        offer(2'd0, 5'd8, 8'hEE, 5'd12, 8'hDD, 8'h00, 1'b0, 5'd13, 1'b0);
        #1 chk("stall_c1_ready", {31'd0, id_ready}, 32'd0);
        tick();
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 8'h40;
        #1 chk("stall_c2_ready", {31'd0, id_ready}, 32'd0);
        chk("stall_c2_in1", {24'd0, alu_in_1}, 32'h0000_0010);
        tick();
        wb_reg_write = 1'b0;
        #1 chk("stall_c3_ready", {31'd0, id_ready}, 32'd0);
        chk("stall_c3_in1", {24'd0, alu_in_1}, 32'h0000_0040);
        tick();
        chk("stall_hold_in1", {24'd0, alu_in_1}, 32'h0000_0040);
        chk("stall_hold_in2", {24'd0, alu_in_2}, 32'h0000_0005);
        chk("stall_hold_rd", {27'd0, ex_rd}, 32'd11);
        chk("stall_hold_valid", {31'd0, ex_valid}, 32'd1);
        ex_ready = 1'b1;
        sb_push(2'd0, 8'hEE, 8'hDD, 5'd13, 1'b0);
        tick();
        id_valid = 1'b0;
        sb_pop("stall_release");

        // Flush kills a same-cycle transfer
        offer(2'd2, 5'd1, 8'h31, 5'd2, 8'h32, 8'h00, 1'b0, 5'd5, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0; id_valid = 1'b0;
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);
        offer(2'd3, 5'd1, 8'h41, 5'd2, 8'h42, 8'h00, 1'b0, 5'd14, 1'b1);
        sb_push(2'd3, 8'h41, 8'h42, 5'd14, 1'b1);
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        sb_pop("post_flush");

        // Reset mid-stall drops the instruction without a clock edge
        tick();
        chk("prerst_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("midrst_ready", {31'd0, id_ready}, 32'd1);
        rst_n = 1'b1;

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
